// File: rtl/vga_capture.sv
// VGA timing receiver: recovers x/y from hsync/vsync, locks after clean frames, counts white pixels per frame.
// Optional per-frame rgb checksum on frame_sum when VGA_CAPTURE_CHECKSUM_EN is defined.
module vga_capture #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p_tick,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [11:0] rgb,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        pix_valid,
  output logic [11:0] pix_rgb,
  output logic        locked,
  output logic        line_err,
  output logic        frame_err,
  output logic        stats_valid,
  output logic [18:0] frame_white,
  output logic [15:0] frame_sum
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_START = H_SYNC + H_BP;
  localparam int V_START = V_SYNC + V_BP;

  typedef enum logic [1:0] {SEARCH = 2'd0, MEASURE = 2'd1, LOCKED = 2'd2} state_t;

  state_t      state_q, state_d;
  logic        hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
  logic [9:0]  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d, fr_lines_q, fr_lines_d;
  logic        h_seen_q, h_seen_d, vs_seen_q, vs_seen_d;
  logic        vs_pend_q, vs_pend_d, err_seen_q, err_seen_d;
  logic [7:0]  good_q, good_d;
  logic [18:0] white_acc_q, white_acc_d, frame_white_q, frame_white_d;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic        pix_valid_q, pix_valid_d, locked_q, locked_d;
  logic [11:0] pix_rgb_q, pix_rgb_d;
  logic        line_err_q, line_err_d, frame_err_q, frame_err_d;
  logic        stats_valid_q, stats_valid_d;

  logic        hs_fall, vs_fall, lerr, ferr;
  logic        active, valid, stat_latch, acc_clr;
  logic [10:0] fr_lines_tot;

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

  assign hs_fall = p_tick & hs_prev_q & ~hsync;
  assign vs_fall = p_tick & vs_prev_q & ~vsync;
  // an hsync fall on the same tick as the vsync fall still belongs to the closing frame
  assign fr_lines_tot = {1'b0, fr_lines_q} + {10'd0, hs_fall};
  assign lerr = hs_fall & h_seen_q & (({1'b0, h_cnt_q} + 11'd1) != 11'(H_TOTAL));
  assign ferr = vs_fall & vs_seen_q & (fr_lines_tot != 11'(V_TOTAL));

  always_comb begin
    state_d       = state_q;
    hs_prev_d     = hs_prev_q;
    vs_prev_d     = vs_prev_q;
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    fr_lines_d    = fr_lines_q;
    h_seen_d      = h_seen_q;
    vs_seen_d     = vs_seen_q;
    vs_pend_d     = vs_pend_q;
    err_seen_d    = err_seen_q;
    good_d        = good_q;
    white_acc_d   = white_acc_q;
    frame_white_d = frame_white_q;
    x_d           = x_q;
    y_d           = y_q;
    pix_valid_d   = pix_valid_q;
    pix_rgb_d     = pix_rgb_q;
    locked_d      = locked_q;
    line_err_d    = 1'b0;
    frame_err_d   = 1'b0;
    stats_valid_d = 1'b0;
    active        = 1'b0;
    valid         = 1'b0;
    stat_latch    = 1'b0;
    acc_clr       = 1'b0;
    if (p_tick) begin
      hs_prev_d = hsync;
      vs_prev_d = vsync;
      h_cnt_d   = hs_fall ? 10'd0 : sat_inc(h_cnt_q);
      if (hs_fall) begin
        h_seen_d   = 1'b1;
        v_cnt_d    = vs_pend_q ? 10'd0 : sat_inc(v_cnt_q);
        fr_lines_d = sat_inc(fr_lines_q);
      end
      // hsync consumes the old pending flag; a coincident vsync fall re-arms it
      vs_pend_d  = (vs_pend_q & ~hs_fall) | vs_fall;
      err_seen_d = err_seen_q | lerr;
      if (vs_fall) begin
        vs_seen_d  = 1'b1;
        fr_lines_d = 10'd0;
        err_seen_d = 1'b0;
      end
      case (state_q)
        SEARCH: if (vs_fall) begin
          state_d = MEASURE;
          good_d  = 8'd0;
        end
        MEASURE: if (vs_fall) begin
          if (err_seen_q | lerr | ferr) good_d = 8'd0;
          else begin
            good_d = good_q + 8'd1;
            if (good_q + 8'd1 >= 8'(LOCK_FRAMES)) state_d = LOCKED;
          end
        end
        LOCKED: begin
          if (lerr | ferr) begin
            state_d = MEASURE;
            good_d  = 8'd0;
            acc_clr = 1'b1;
          end else if (vs_fall) stat_latch = 1'b1;
        end
        default: state_d = SEARCH;
      endcase
      active = (h_cnt_d >= 10'(H_START)) && (h_cnt_d < 10'(H_START + H_ACTIVE)) &&
               (v_cnt_d >= 10'(V_START)) && (v_cnt_d < 10'(V_START + V_ACTIVE));
      valid         = active && (state_d == LOCKED);
      x_d           = h_cnt_d - 10'(H_START);
      y_d           = v_cnt_d - 10'(V_START);
      pix_valid_d   = valid;
      pix_rgb_d     = rgb;
      locked_d      = (state_d == LOCKED);
      line_err_d    = lerr;
      frame_err_d   = ferr;
      stats_valid_d = stat_latch;
      if (stat_latch) frame_white_d = white_acc_q;
      white_acc_d = ((stat_latch | acc_clr) ? 19'd0 : white_acc_q) +
                    {18'd0, valid && (rgb == 12'hFFF)};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= SEARCH;
      hs_prev_q     <= 1'b0;
      vs_prev_q     <= 1'b0;
      h_cnt_q       <= 10'd0;
      v_cnt_q       <= 10'd0;
      fr_lines_q    <= 10'd0;
      h_seen_q      <= 1'b0;
      vs_seen_q     <= 1'b0;
      vs_pend_q     <= 1'b0;
      err_seen_q    <= 1'b0;
      good_q        <= 8'd0;
      white_acc_q   <= 19'd0;
      frame_white_q <= 19'd0;
      x_q           <= 10'd0;
      y_q           <= 10'd0;
      pix_valid_q   <= 1'b0;
      pix_rgb_q     <= 12'd0;
      locked_q      <= 1'b0;
      line_err_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      stats_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      hs_prev_q     <= hs_prev_d;
      vs_prev_q     <= vs_prev_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      fr_lines_q    <= fr_lines_d;
      h_seen_q      <= h_seen_d;
      vs_seen_q     <= vs_seen_d;
      vs_pend_q     <= vs_pend_d;
      err_seen_q    <= err_seen_d;
      good_q        <= good_d;
      white_acc_q   <= white_acc_d;
      frame_white_q <= frame_white_d;
      x_q           <= x_d;
      y_q           <= y_d;
      pix_valid_q   <= pix_valid_d;
      pix_rgb_q     <= pix_rgb_d;
      locked_q      <= locked_d;
      line_err_q    <= line_err_d;
      frame_err_q   <= frame_err_d;
      stats_valid_q <= stats_valid_d;
    end
  end

`ifdef VGA_CAPTURE_CHECKSUM_EN
  logic [15:0] sum_acc_q, sum_acc_d, frame_sum_q, frame_sum_d;

  always_comb begin
    sum_acc_d   = sum_acc_q;
    frame_sum_d = frame_sum_q;
    if (p_tick) begin
      if (stat_latch) frame_sum_d = sum_acc_q;
      sum_acc_d = ((stat_latch | acc_clr) ? 16'd0 : sum_acc_q) + (valid ? {4'd0, rgb} : 16'd0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_acc_q   <= 16'd0;
      frame_sum_q <= 16'd0;
    end else begin
      sum_acc_q   <= sum_acc_d;
      frame_sum_q <= frame_sum_d;
    end
  end

  assign frame_sum = frame_sum_q;
`else
  assign frame_sum = 16'd0;
`endif

  assign x           = x_q;
  assign y           = y_q;
  assign pix_valid   = pix_valid_q;
  assign pix_rgb     = pix_rgb_q;
  assign locked      = locked_q;
  assign line_err    = line_err_q;
  assign frame_err   = frame_err_q;
  assign stats_valid = stats_valid_q;
  assign frame_white = frame_white_q;

endmodule

// File: tb/tb_vga_capture.sv
// Scoreboard bench for vga_capture on a scaled-down raster (25x13 total, 16x8 active).
module tb_vga_capture;
  localparam int HT = 25;
  localparam int HS = 7;          // first active column
  localparam int HE = 23;         // one past last active column
  localparam int VS = 4;          // first active line
  localparam int VE = 12;
  localparam int VS_OFF = 23;     // vsync falls in the front porch of the last line
`ifdef VGA_CAPTURE_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic        clk = 1'b0, reset = 1'b1, p_tick = 1'b0, hsync = 1'b1, vsync = 1'b1;
  logic [11:0] rgb = 12'd0;
  logic [9:0]  x, y;
  logic        pix_valid, locked, line_err, frame_err, stats_valid;
  logic [11:0] pix_rgb;
  logic [18:0] frame_white;
  logic [15:0] frame_sum;

  typedef struct { logic [9:0] x; logic [9:0] y; logic [11:0] c; } pix_t;
  typedef struct { logic [18:0] w; logic [15:0] s; } st_t;
  pix_t pq[$];
  st_t  sq[$];

  int total = 0, bad = 0, lerr_cnt = 0, ferr_cnt = 0;
  int prev_vs_off = VS_OFF;
  bit exp_on = 1'b0;

  vga_capture #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(2), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .reset(reset), .p_tick(p_tick), .hsync(hsync), .vsync(vsync), .rgb(rgb),
    .x(x), .y(y), .pix_valid(pix_valid), .pix_rgb(pix_rgb), .locked(locked),
    .line_err(line_err), .frame_err(frame_err), .stats_valid(stats_valid),
    .frame_white(frame_white), .frame_sum(frame_sum)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_pix_valid"}, pix_valid, 0);
    chk({tag, "_x"}, x, 0);
    chk({tag, "_y"}, y, 0);
    chk({tag, "_pix_rgb"}, pix_rgb, 0);
    chk({tag, "_white"}, frame_white, 0);
    chk({tag, "_sum"}, frame_sum, 0);
    chk({tag, "_stats_valid"}, stats_valid, 0);
    chk({tag, "_line_err"}, line_err, 0);
    chk({tag, "_frame_err"}, frame_err, 0);
  endtask

  // one pixel: p_tick high for one clk out of every four
  task automatic do_tick(input logic hs, input logic vs, input logic [11:0] c);
    @(negedge clk);
    hsync = hs; vsync = vs; rgb = c; p_tick = 1'b1;
    @(negedge clk);
    p_tick = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic reset_mid();
    #2 reset = 1'b0;
    #1 chk_all_zero("rst_mid");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // pat: 0 = black with 3x3 white square at (5,3), 1 = all white, 2 = rgb = y*16+x
  task automatic send_frame(input int lines, input int short_ln, input int pat, input bit ev,
                            input bit est, input int ew, input int es, input bit pre,
                            input bit post, input int vs_off, input int rst_ln);
    exp_on = ev;
    for (int v = 0; v < lines; v++) begin
      int hlen;
      hlen = (v == short_ln) ? HT - 1 : HT;
      if (short_ln >= 0 && v > short_ln) exp_on = 1'b0;
      for (int h = 0; h < hlen; h++) begin
        logic [11:0] c;
        logic        vs;
        bit          act;
        pix_t        p;
        st_t         s;
        act = (h >= HS && h < HE && v >= VS && v < VE);
        c = 12'd0;
        if (act) begin
          case (pat)
            0: c = (h - HS >= 5 && h - HS <= 7 && v - VS >= 3 && v - VS <= 5) ? 12'hFFF : 12'h000;
            1: c = 12'hFFF;
            default: c = 12'((v - VS) * 16 + (h - HS));
          endcase
        end
        vs = !((v == 0) || (v == 1 && h < prev_vs_off) || (v == lines - 1 && h >= vs_off));
        if (act && exp_on) begin
          p.x = 10'(h - HS); p.y = 10'(v - VS); p.c = c;
          pq.push_back(p);
        end
        if (v == lines - 1 && h == vs_off) begin
          chk("locked_before_vfall", locked, 32'(pre));
          if (est) begin
            s.w = 19'(ew); s.s = CSUM ? 16'(es) : 16'd0;
            sq.push_back(s);
          end
        end
        do_tick(h >= 4, vs, c);
        if (v == lines - 1 && h == vs_off) chk("locked_after_vfall", locked, 32'(post));
        if (short_ln >= 0 && v == short_ln + 1 && h == 0) begin
          chk("locked_drop_on_line_err", locked, 0);
          chk("line_err_pulses", lerr_cnt, 1);
        end
        if (v == rst_ln && h == 10) begin
          chk("pix_valid_before_reset", pix_valid, 1);
          reset_mid();
          exp_on = 1'b0;
        end
      end
    end
    prev_vs_off = vs_off;
  endtask

  // monitor: one look per pixel tick, after the sampling edge has settled
  initial begin : monitor
    pix_t p;
    st_t  s;
    forever begin
      @(posedge clk);
      if (p_tick === 1'b1 && reset === 1'b1) begin
        #1;
        if (line_err === 1'b1) lerr_cnt++;
        if (frame_err === 1'b1) ferr_cnt++;
        if (pix_valid === 1'b1) begin
          if (pq.size() == 0) chk("pix_unexpected", 1, 0);
          else begin
            p = pq.pop_front();
            chk("pix_x", x, p.x);
            chk("pix_y", y, p.y);
            chk("pix_rgb", pix_rgb, p.c);
          end
        end
        if (stats_valid === 1'b1) begin
          if (sq.size() == 0) chk("stats_unexpected", 1, 0);
          else begin
            s = sq.pop_front();
            chk("frame_white", frame_white, s.w);
            chk("frame_sum", frame_sum, s.s);
          end
        end
      end
    end
  end

  initial begin
    #3 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("rst_init");
    reset = 1'b1;
    //          lines sh pat ev est  w    sum      pre post vsoff   rst
    send_frame(13, -1, 0, 0, 0,   0, 0,      0, 0, VS_OFF, -1);
    send_frame(13, -1, 0, 0, 0,   0, 0,      0, 0, VS_OFF, -1);
    send_frame(13, -1, 0, 0, 0,   0, 0,      0, 1, VS_OFF, -1);
    send_frame(13, -1, 0, 1, 1,   9, 16'h8FF7, 1, 1, VS_OFF, -1);
    send_frame(13, -1, 2, 1, 1,   0, 16'h1FC0, 1, 1, VS_OFF, -1);
    send_frame(13, -1, 1, 1, 1, 128, 16'hFF80, 1, 1, VS_OFF, -1);
    send_frame(13, -1, 0, 1, 1,   9, 16'h8FF7, 1, 1, 0,      -1);
    send_frame(13, -1, 0, 1, 1,   9, 16'h8FF7, 1, 1, VS_OFF, -1);
    send_frame(13,  6, 0, 1, 0,   0, 0,      0, 0, VS_OFF, -1);
    send_frame(13, -1, 0, 0, 0,   0, 0,      0, 0, VS_OFF, -1);
    send_frame(13, -1, 0, 0, 0,   0, 0,      0, 1, VS_OFF, -1);
    send_frame(13, -1, 0, 1, 1,   9, 16'h8FF7, 1, 1, VS_OFF, -1);
    send_frame(12, -1, 1, 1, 0,   0, 0,      1, 0, VS_OFF, -1);
    chk("frame_err_pulses", ferr_cnt, 1);
    chk("white_held_after_frame_err", frame_white, 9);
    send_frame(13, -1, 0, 0, 0,   0, 0,      0, 0, VS_OFF, -1);
    chk("white_held_in_measure", frame_white, 9);
    send_frame(13, -1, 0, 0, 0,   0, 0,      0, 1, VS_OFF, -1);
    send_frame(13, -1, 0, 1, 1,   9, 16'h8FF7, 1, 1, VS_OFF, -1);
    send_frame(13, -1, 1, 1, 0,   0, 0,      0, 0, VS_OFF, 6);
    send_frame(13, -1, 0, 0, 0,   0, 0,      0, 0, VS_OFF, -1);
    send_frame(13, -1, 0, 0, 0,   0, 0,      0, 1, VS_OFF, -1);
    send_frame(13, -1, 2, 1, 1,   0, 16'h1FC0, 1, 1, VS_OFF, -1);
    repeat (8) @(negedge clk);
    chk("pix_queue_drained", pq.size(), 0);
    chk("stats_queue_drained", sq.size(), 0);
    chk("line_err_total", lerr_cnt, 1);
    chk("frame_err_total", ferr_cnt, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
